// File: rtl/storage_arbiter.sv
// -----------------------------------------------------------------------------
// storage_arbiter
//
// Arbitrates four requesters (tank1, tank2, proj1, proj2) onto a single
// position/direction storage block. A round-robin pick is made in IDLE, the
// chosen command is issued for one cycle, the storage is given LAT idle
// cycles to settle, and reads additionally strobe the storage output and
// capture the returned position/direction before the completion pulse.
//
// Parameters
//   LAT            idle cycles (0..7) between command issue and completion
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   req[3:0]       request per requester (0=tank1 1=tank2 2=proj1 3=proj2)
//   req_we[3:0]    per requester: 1=write, 0=read
//   req_addr[31:0] per requester 8-bit address, requester i in [8i+7:8i]
//   req_data[31:0] per requester 8-bit write data, requester i in [8i+7:8i]
//   gnt[3:0]       one-hot owner of the storage, ISSUE through ACK
//   ack[3:0]       one-hot, one-cycle completion pulse
//   rd_pos/rd_dir  values captured by the most recent read
//   busy           high whenever a transaction is in flight
//   st_mode        storage mode select derived from the granted index
//   st_wren        storage write enable (ISSUE cycle of a write only)
//   st_load_out    storage output-load strobe (LOAD cycle of a read)
//   st_address     storage address, held ISSUE through ACK
//   st_data        storage write data, held ISSUE through ACK
//   st_updated_pos storage position readback
//   st_updated_dir storage direction readback
// -----------------------------------------------------------------------------
module storage_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [7:0]  rd_pos,
  output logic [7:0]  rd_dir,
  output logic        busy,
  output logic [3:0]  st_mode,
  output logic        st_wren,
  output logic        st_load_out,
  output logic [7:0]  st_address,
  output logic [7:0]  st_data,
  input  logic [7:0]  st_updated_pos,
  input  logic [7:0]  st_updated_dir
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    LOAD    = 3'd3,
    CAPTURE = 3'd4,
    ACK     = 3'd5
  } state_t;

  // Preload value for the wait counter: it counts down to zero, so LAT
  // cycles of WAIT need a start value of LAT-1.
  localparam logic [2:0] LAT_M1 = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  // ---------------------------------------------------------------------------
  // State and latched transaction
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  // Next values of the registered outputs.
  logic [3:0]  gnt_d, ack_d, st_mode_d;
  logic        busy_d, st_wren_d, st_load_out_d;
  logic [7:0]  st_address_d, st_data_d;
  logic [7:0]  rd_pos_d, rd_dir_d;

  // ---------------------------------------------------------------------------
  // Round-robin selection: scan from last_grant+1 upwards, wrapping mod 4.
  // The 2-bit sum wraps naturally, so no explicit modulo is needed.
  // ---------------------------------------------------------------------------
  logic        rr_valid;
  logic [1:0]  rr_idx;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    rr_valid = 1'b0;
    rr_idx   = 2'(last_grant_q + 2'd1);
    for (int i = 0; i < 4; i++) begin
      if (!rr_valid && req[2'(last_grant_q + 2'(i + 1))]) begin
        rr_valid = 1'b1;
        rr_idx   = 2'(last_grant_q + 2'(i + 1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;

    unique case (state_q)
      IDLE: begin
        // The request is latched here so later req changes cannot disturb
        // the transaction in flight.
        if (rr_valid) begin
          idx_d   = rr_idx;
          we_d    = req_we[rr_idx];
          addr_d  = req_addr[{rr_idx, 3'b000} +: 8];
          data_d  = req_data[{rr_idx, 3'b000} +: 8];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (LAT == 0) begin
          state_d = we_q ? ACK : LOAD;
        end else begin
          wait_cnt_d = LAT_M1;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = we_q ? ACK : LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

      LOAD:    state_d = CAPTURE;

      CAPTURE: state_d = ACK;

      ACK: begin
        last_grant_d = idx_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are registered, so they are decoded from the
  // state being entered (state_d) and the transaction being latched, which
  // makes every output line up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d         = 4'b0000;
    ack_d         = 4'b0000;
    busy_d        = 1'b0;
    st_mode_d     = 4'b0000;
    st_wren_d     = 1'b0;
    st_load_out_d = 1'b0;
    st_address_d  = 8'h00;
    st_data_d     = 8'h00;
    rd_pos_d      = rd_pos;
    rd_dir_d      = rd_dir;

    if (state_d != IDLE) begin
      gnt_d        = 4'b0001 << idx_d;
      busy_d       = 1'b1;
      // Requester 0..3 maps to odd modes 1,3,5,7.
      st_mode_d    = {1'b0, idx_d, 1'b1};
      st_address_d = addr_d;
      st_data_d    = data_d;
    end

    if (state_d == ISSUE) st_wren_d = we_d;
    if (state_d == LOAD)  st_load_out_d = 1'b1;
    if (state_d == ACK)   ack_d = 4'b0001 << idx_d;

    // Readback is sampled during CAPTURE and presented from ACK onwards.
    if (state_q == CAPTURE) begin
      rd_pos_d = st_updated_pos;
      rd_dir_d = st_updated_dir;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 3'd0;
      // Requester 0 wins the first arbitration after reset.
      last_grant_q <= 2'd3;
      idx_q        <= 2'd0;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      gnt          <= 4'b0000;
      ack          <= 4'b0000;
      busy         <= 1'b0;
      st_mode      <= 4'b0000;
      st_wren      <= 1'b0;
      st_load_out  <= 1'b0;
      st_address   <= 8'h00;
      st_data      <= 8'h00;
      rd_pos       <= 8'h00;
      rd_dir       <= 8'h00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      gnt          <= gnt_d;
      ack          <= ack_d;
      busy         <= busy_d;
      st_mode      <= st_mode_d;
      st_wren      <= st_wren_d;
      st_load_out  <= st_load_out_d;
      st_address   <= st_address_d;
      st_data      <= st_data_d;
      rd_pos       <= rd_pos_d;
      rd_dir       <= rd_dir_d;
    end
  end

endmodule

// File: tb/tb_storage_arbiter.sv
// -----------------------------------------------------------------------------
// tb_storage_arbiter
//
// Two arbiters (LAT=1 and LAT=0) share one stimulus stream. A transaction-
// level model predicts, per cycle, what each must present: when an idle
// cycle sees requests, the model picks a requester round-robin and lays out
// the whole cycle-by-cycle timeline of that transaction. Directed scenarios
// with hand-computed literal values pin the model, followed by random
// traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_storage_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  st_updated_pos;
  logic [7:0]  st_updated_dir;

  logic [3:0]  gnt_o      [2];
  logic [3:0]  ack_o      [2];
  logic [3:0]  st_mode_o  [2];
  logic        busy_o     [2];
  logic        st_wren_o  [2];
  logic        st_load_o  [2];
  logic [7:0]  st_addr_o  [2];
  logic [7:0]  st_data_o  [2];
  logic [7:0]  rd_pos_o   [2];
  logic [7:0]  rd_dir_o   [2];

  int vectors     = 0;
  int miscompares = 0;

  storage_arbiter #(.LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt_o[0]), .ack(ack_o[0]), .rd_pos(rd_pos_o[0]), .rd_dir(rd_dir_o[0]),
    .busy(busy_o[0]), .st_mode(st_mode_o[0]), .st_wren(st_wren_o[0]),
    .st_load_out(st_load_o[0]), .st_address(st_addr_o[0]), .st_data(st_data_o[0]),
    .st_updated_pos(st_updated_pos), .st_updated_dir(st_updated_dir)
  );

  storage_arbiter #(.LAT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt_o[1]), .ack(ack_o[1]), .rd_pos(rd_pos_o[1]), .rd_dir(rd_dir_o[1]),
    .busy(busy_o[1]), .st_mode(st_mode_o[1]), .st_wren(st_wren_o[1]),
    .st_load_out(st_load_o[1]), .st_address(st_addr_o[1]), .st_data(st_data_o[1]),
    .st_updated_pos(st_updated_pos), .st_updated_dir(st_updated_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       busy;
    logic       wren;
    logic       load;
    logic       cap;
    logic [3:0] mode;
    logic [7:0] addr;
    logic [7:0] data;
  } rec_t;

  int         lat_of [2] = '{1, 0};
  rec_t       seq    [2][12];
  int         seq_len[2];
  int         seq_pos[2];
  rec_t       cur    [2];
  int         last_g [2];
  logic [7:0] rdp_m  [2];
  logic [7:0] rdd_m  [2];

  initial begin
    for (int n = 0; n < 2; n++) begin
      seq_len[n] = 0; seq_pos[n] = 0; cur[n] = '0;
      last_g[n] = 3; rdp_m[n] = 8'h00; rdd_m[n] = 8'h00;
    end
  end

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return (last + off) % 4;
    end
    return -1;
  endfunction

  // Lay out one transaction: ISSUE, LAT waits, (LOAD, CAPTURE if read), ACK.
  task automatic build_txn(input int n, input int j);
    rec_t r;
    int   k;
    logic we;
    we     = req_we[j];
    r      = '0;
    r.gnt  = 4'(1 << j);
    r.busy = 1'b1;
    r.mode = 4'(2 * j + 1);
    r.addr = req_addr[8*j +: 8];
    r.data = req_data[8*j +: 8];
    k = 0;
    seq[n][k] = r; seq[n][k].wren = we; k++;
    for (int w = 0; w < lat_of[n]; w++) begin
      seq[n][k] = r; k++;
    end
    if (!we) begin
      seq[n][k] = r; seq[n][k].load = 1'b1; k++;
      seq[n][k] = r; seq[n][k].cap  = 1'b1; k++;
    end
    seq[n][k] = r; seq[n][k].ack = r.gnt; k++;
    seq_len[n] = k;
    seq_pos[n] = 0;
  endtask

  // Advance the model from the cycle just compared to the next one.
  task automatic step_model(input int n);
    int j;
    if (!reset) begin
      seq_len[n] = 0; seq_pos[n] = 0; cur[n] = '0;
      last_g[n] = 3; rdp_m[n] = 8'h00; rdd_m[n] = 8'h00;
      return;
    end
    if (cur[n].cap) begin
      rdp_m[n] = st_updated_pos;
      rdd_m[n] = st_updated_dir;
    end
    for (int b = 0; b < 4; b++) if (cur[n].ack[b]) last_g[n] = b;
    if (seq_pos[n] < seq_len[n]) begin
      cur[n] = seq[n][seq_pos[n]];
      seq_pos[n]++;
    end else if (cur[n].busy) begin
      cur[n] = '0;                       // mandatory idle cycle after ACK
    end else begin
      j = rr_pick(last_g[n], req);
      if (j >= 0) begin
        build_txn(n, j);
        cur[n] = seq[n][0];
        seq_pos[n] = 1;
      end else begin
        cur[n] = '0;
      end
    end
  endtask

  task automatic compare_one(input int n);
    rec_t       e;
    logic [7:0] ep, ed;
    string      p;
    p  = $sformatf("lat%0d.", lat_of[n]);
    e  = reset ? cur[n] : '0;
    ep = reset ? rdp_m[n] : 8'h00;
    ed = reset ? rdd_m[n] : 8'h00;
    check({p, "gnt"},         32'(gnt_o[n]),     32'(e.gnt));
    check({p, "ack"},         32'(ack_o[n]),     32'(e.ack));
    check({p, "busy"},        32'(busy_o[n]),    32'(e.busy));
    check({p, "st_mode"},     32'(st_mode_o[n]), 32'(e.mode));
    check({p, "st_wren"},     32'(st_wren_o[n]), 32'(e.wren));
    check({p, "st_load_out"}, 32'(st_load_o[n]), 32'(e.load));
    check({p, "st_address"},  32'(st_addr_o[n]), 32'(e.addr));
    check({p, "st_data"},     32'(st_data_o[n]), 32'(e.data));
    check({p, "rd_pos"},      32'(rd_pos_o[n]),  32'(ep));
    check({p, "rd_dir"},      32'(rd_dir_o[n]),  32'(ed));
    check({p, "gnt_onehot"},  32'($countones(gnt_o[n]) <= 1), 32'd1);
  endtask

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      compare_one(n);
      step_model(n);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change 1 time unit after the rising edge; directed
  // literal checks sample on the falling edge. Cycle c=0 of each scenario is
  // the idle cycle that first sees the request.
  // ---------------------------------------------------------------------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      drive_edge();
      req = 4'b0000;
    end
  endtask

  initial begin
    reset          = 1'b0;
    req            = 4'b0000;
    req_we         = 4'b0000;
    req_addr       = 32'h0;
    req_data       = 32'h0;
    st_updated_pos = 8'h00;
    st_updated_dir = 8'h00;

    // Reset state
    @(negedge clk);
    check("reset_gnt",  32'(gnt_o[0]),     32'h0);
    check("reset_busy", 32'(busy_o[0]),    32'h0);
    check("reset_mode", 32'(st_mode_o[0]), 32'h0);
    check("reset_rd",   32'(rd_pos_o[0]),  32'h0);
    drive_edge();
    reset = 1'b1;
    idle_cycles(2);

    // Write from requester 0, LAT=1: ack in cycle 3, readback untouched.
    for (int c = 0; c < 6; c++) begin
      drive_edge();
      req      = (c == 0) ? 4'b0001 : 4'b0000;
      req_we   = 4'hF;
      req_addr = {4{8'h12}};
      req_data = {4{8'h05}};
      @(negedge clk);
      if (c == 1) begin
        check("w_issue_mode", 32'(st_mode_o[0]), 32'h1);
        check("w_issue_addr", 32'(st_addr_o[0]), 32'h12);
        check("w_issue_data", 32'(st_data_o[0]), 32'h05);
        check("w_issue_wren", 32'(st_wren_o[0]), 32'h1);
        check("w_issue_gnt",  32'(gnt_o[0]),     32'h1);
      end
      if (c == 2) check("w_wait_wren", 32'(st_wren_o[0]), 32'h0);
      if (c == 3) begin
        check("w_ack",    32'(ack_o[0]),    32'h1);
        check("w_rd_pos", 32'(rd_pos_o[0]), 32'h0);
      end
      if (c == 4) begin
        check("w_idle_mode", 32'(st_mode_o[0]), 32'h0);
        check("w_idle_gnt",  32'(gnt_o[0]),     32'h0);
      end
    end

    // Read from requester 2: storage returns 0x34/0x05.
    for (int c = 0; c < 8; c++) begin
      drive_edge();
      req      = (c == 0) ? 4'b0100 : 4'b0000;
      req_we   = 4'h0;
      req_addr = {4{8'h12}};
      st_updated_pos = (c < 5) ? 8'h34 : 8'($urandom);
      st_updated_dir = (c < 5) ? 8'h05 : 8'($urandom);
      @(negedge clk);
      if (c == 1) check("r_mode", 32'(st_mode_o[0]), 32'h5);
      if (c == 3) check("r_load", 32'(st_load_o[0]), 32'h1);
      if (c == 5) begin
        check("r_ack",    32'(ack_o[0]),    32'h4);
        check("r_rd_pos", 32'(rd_pos_o[0]), 32'h34);
        check("r_rd_dir", 32'(rd_dir_o[0]), 32'h05);
      end
      if (c == 2) check("r0_load", 32'(st_load_o[1]), 32'h1);
      if (c == 4) begin
        check("r0_ack",    32'(ack_o[1]),    32'h4);
        check("r0_rd_pos", 32'(rd_pos_o[1]), 32'h34);
      end
      if (c == 7) check("r_rd_hold", 32'(rd_pos_o[0]), 32'h34);
    end

    // Write from requester 1 with req dropped after ISSUE: still completes.
    for (int c = 0; c < 6; c++) begin
      drive_edge();
      req    = (c < 2) ? 4'b0010 : 4'b0000;
      req_we = 4'hF;
      @(negedge clk);
      if (c == 3) begin
        check("drop_ack",    32'(ack_o[0]),    32'h2);
        check("drop_rd_pos", 32'(rd_pos_o[0]), 32'h34);
      end
    end

    // All four writing continuously from reset: 0,1,2,3,0 four cycles apart.
    drive_edge();
    reset = 1'b0;
    for (int c = 0; c < 21; c++) begin
      drive_edge();
      reset  = 1'b1;
      req    = 4'b1111;
      req_we = 4'hF;
      @(negedge clk);
      if (c == 3)  check("rr_ack0", 32'(ack_o[0]), 32'h1);
      if (c == 7)  check("rr_ack1", 32'(ack_o[0]), 32'h2);
      if (c == 11) check("rr_ack2", 32'(ack_o[0]), 32'h4);
      if (c == 15) check("rr_ack3", 32'(ack_o[0]), 32'h8);
      if (c == 19) check("rr_ack4", 32'(ack_o[0]), 32'h1);
    end
    idle_cycles(10);

    // Reset during WAIT of a read: outputs clear at once, no ack; then
    // requester 0 is granted first.
    for (int c = 0; c < 8; c++) begin
      drive_edge();
      if (c == 0) begin req = 4'b0001; req_we = 4'h0; end
      else if (c == 2) begin reset = 1'b0; req = 4'b0000; end
      else if (c == 3) begin reset = 1'b1; req = 4'b1111; req_we = 4'hF; end
      @(negedge clk);
      if (c == 1) check("rst_pre_gnt", 32'(gnt_o[0]), 32'h1);
      if (c == 2) begin
        check("rst_gnt",    32'(gnt_o[0]),     32'h0);
        check("rst_busy",   32'(busy_o[0]),    32'h0);
        check("rst_mode",   32'(st_mode_o[0]), 32'h0);
        check("rst_rd_pos", 32'(rd_pos_o[0]),  32'h0);
      end
      if (c == 3) check("rst_no_ack",   32'(ack_o[0]), 32'h0);
      if (c == 4) check("rst_then_gnt", 32'(gnt_o[0]), 32'h1);
      if (c == 6) check("rst_then_ack", 32'(ack_o[0]), 32'h1);
    end
    idle_cycles(10);

    // Random traffic with occasional one-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      drive_edge();
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else req = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      req_we         = 4'($urandom);
      req_addr       = $urandom;
      req_data       = $urandom;
      st_updated_pos = 8'($urandom);
      st_updated_dir = 8'($urandom);
    end
    drive_edge();
    reset = 1'b1;
    idle_cycles(12);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
